// File: rtl/irq_ctrl.sv
// Nesting-aware N-channel interrupt controller: latches requests, applies an
// enable mask and presents the highest eligible channel above the in-service level.
module irq_ctrl #(
  parameter int N    = 3,
  parameter int IDW  = 2,
  parameter int EDGE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   irq,
  input  logic           mask_we,
  input  logic [N-1:0]   mask_wdata,
  input  logic           int_ack,
  input  logic           int_ret,
  input  logic           ovf_clr,
  output logic           int_req,
  output logic [IDW-1:0] int_id,
  output logic [N-1:0]   irw,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   ovf
);

  logic [N-1:0]   irq_dly_q, pending_q, mask_q, irw_q, ovf_q;
  logic [N-1:0]   irq_dly_d, pending_d, mask_d, irw_d, ovf_d;
  logic [N-1:0]   above_top, eligible, top_oh, id_oh, ack_oh, set_ev;
  logic [IDW-1:0] id_c;
  logic           seen, ack_acc;

  // Priority resolution uses registered state only, so no input-to-output path.
  always_comb begin
    seen      = 1'b0;
    above_top = '0;
    top_oh    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (irw_q[i] && !seen) top_oh[i] = 1'b1;
      seen         = seen | irw_q[i];
      above_top[i] = ~seen;
    end
    eligible = pending_q & mask_q & above_top;
    id_c     = '0;
    id_oh    = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) begin
        id_c     = IDW'(i);
        id_oh    = '0;
        id_oh[i] = 1'b1;
      end
    end
  end

  assign int_req = |eligible;
  assign int_id  = id_c;
  assign irw     = irw_q;
  assign pending = pending_q;
  assign ovf     = ovf_q;

  always_comb begin
    ack_acc   = int_ack & int_req;
    ack_oh    = ack_acc ? id_oh : '0;
    set_ev    = irq & ~irq_dly_q;
    irq_dly_d = irq;
    mask_d    = mask_we ? mask_wdata : mask_q;
    irw_d     = (irw_q & ~(int_ret ? top_oh : '0)) | ack_oh;
    if (EDGE != 0) begin
      // A set event in the same edge as the ack of that channel wins and is not an overrun.
      pending_d = (pending_q & ~ack_oh) | set_ev;
      ovf_d     = (ovf_q & ~{N{ovf_clr}}) | (set_ev & pending_q & ~ack_oh);
    end else begin
      pending_d = irq;
      ovf_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_dly_q <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      irw_q     <= '0;
      ovf_q     <= '0;
    end else begin
      irq_dly_q <= irq_dly_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irw_q     <= irw_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised and directed bench for irq_ctrl: an edge-mode and a level-mode
// instance share stimulus and are compared against a per-channel behavioural model.
module tb_irq_ctrl;
  localparam int N   = 3;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   irq = '0;
  logic           mask_we = 1'b0;
  logic [N-1:0]   mask_wdata = '0;
  logic           int_ack = 1'b0;
  logic           int_ret = 1'b0;
  logic           ovf_clr = 1'b0;

  logic           e_req, l_req;
  logic [IDW-1:0] e_id, l_id;
  logic [N-1:0]   e_irw, e_pend, e_ovf, l_irw, l_pend, l_ovf;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state, index 0 = level instance, 1 = edge instance.
  logic [N-1:0] m_pend[2], m_mask[2], m_irw[2], m_ovf[2], m_irqd[2];
  logic [N-1:0] n_pend[2], n_mask[2], n_irw[2], n_ovf[2], n_irqd[2];

  always #5 clk = ~clk;

  irq_ctrl #(.N(N), .IDW(IDW), .EDGE(1)) u_edge (
    .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .int_ack(int_ack), .int_ret(int_ret), .ovf_clr(ovf_clr),
    .int_req(e_req), .int_id(e_id), .irw(e_irw), .pending(e_pend), .ovf(e_ovf)
  );

  irq_ctrl #(.N(N), .IDW(IDW), .EDGE(0)) u_level (
    .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .int_ack(int_ack), .int_ret(int_ret), .ovf_clr(ovf_clr),
    .int_req(l_req), .int_id(l_id), .irw(l_irw), .pending(l_pend), .ovf(l_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Highest in-service index (-1 if none) and highest eligible channel (-1 if none).
  function automatic int top_of(input logic [N-1:0] w);
    int t = -1;
    for (int i = 0; i < N; i++) if (w[i]) t = i;
    return t;
  endfunction

  function automatic int sel_of(input logic [N-1:0] p, input logic [N-1:0] m, input logic [N-1:0] w);
    int s = -1;
    int t = top_of(w);
    for (int i = 0; i < N; i++) if (p[i] && m[i] && i > t) s = i;
    return s;
  endfunction

  task automatic model_reset();
    for (int md = 0; md < 2; md++) begin
      m_pend[md] = '0; m_irw[md] = '0; m_ovf[md] = '0; m_irqd[md] = '0; m_mask[md] = '1;
    end
  endtask

  task automatic model_next(input int md);
    int  t   = top_of(m_irw[md]);
    int  s   = sel_of(m_pend[md], m_mask[md], m_irw[md]);
    bit  ackd = int_ack && (s >= 0);
    n_irw[md]  = m_irw[md];
    n_pend[md] = m_pend[md];
    n_ovf[md]  = m_ovf[md];
    if (int_ret && t >= 0) n_irw[md][t] = 1'b0;
    if (ackd) n_irw[md][s] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (md == 1) begin
        bit setev  = irq[i] && !m_irqd[md][i];
        bit acked  = ackd && (s == i);
        n_pend[md][i] = setev ? 1'b1 : (acked ? 1'b0 : m_pend[md][i]);
        n_ovf[md][i]  = (m_ovf[md][i] && !ovf_clr) || (setev && m_pend[md][i] && !acked);
      end else begin
        n_pend[md][i] = irq[i];
        n_ovf[md][i]  = 1'b0;
      end
    end
    n_irqd[md] = irq;
    n_mask[md] = mask_we ? mask_wdata : m_mask[md];
  endtask

  task automatic check_all();
    int s;
    s = sel_of(m_pend[1], m_mask[1], m_irw[1]);
    check("e_req",  32'(e_req),  32'(s >= 0));
    check("e_id",   32'(e_id),   (s >= 0) ? 32'(s) : 32'd0);
    check("e_irw",  32'(e_irw),  32'(m_irw[1]));
    check("e_pend", 32'(e_pend), 32'(m_pend[1]));
    check("e_ovf",  32'(e_ovf),  32'(m_ovf[1]));
    s = sel_of(m_pend[0], m_mask[0], m_irw[0]);
    check("l_req",  32'(l_req),  32'(s >= 0));
    check("l_id",   32'(l_id),   (s >= 0) ? 32'(s) : 32'd0);
    check("l_irw",  32'(l_irw),  32'(m_irw[0]));
    check("l_pend", 32'(l_pend), 32'(m_pend[0]));
    check("l_ovf",  32'(l_ovf),  32'(m_ovf[0]));
  endtask

  // Drive at the falling edge, advance the model across the rising edge, check at the next falling edge.
  task automatic step(input logic [N-1:0] irq_v, input logic ack = 1'b0, input logic ret = 1'b0,
                      input logic we = 1'b0, input logic [N-1:0] wd = '0, input logic clr = 1'b0);
    irq = irq_v; int_ack = ack; int_ret = ret; mask_we = we; mask_wdata = wd; ovf_clr = clr;
    model_next(0);
    model_next(1);
    @(posedge clk);
    for (int md = 0; md < 2; md++) begin
      m_pend[md] = n_pend[md]; m_irw[md] = n_irw[md]; m_ovf[md] = n_ovf[md];
      m_irqd[md] = n_irqd[md]; m_mask[md] = n_mask[md];
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    check("rst_req", 32'(e_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic request/ack/return.
    step(3'b001);
    check("basic_pend", 32'(e_pend), 32'h1);
    check("basic_req",  32'(e_req),  32'h1);
    step(3'b000, 1'b1);
    check("basic_irw",  32'(e_irw),  32'h1);
    check("basic_noreq", 32'(e_req), 32'h0);
    step(3'b000, 1'b0, 1'b1);
    check("basic_ret",  32'(e_irw),  32'h0);

    // Nesting up to three levels, then unwind.
    step(3'b001); step(3'b000, 1'b1);
    step(3'b010);
    check("nest_id1", 32'(e_id), 32'h1);
    step(3'b000, 1'b1);
    step(3'b100);
    check("nest_id2", 32'(e_id), 32'h2);
    step(3'b000, 1'b1);
    check("nest_irw", 32'(e_irw), 32'h7);
    step(3'b000, 1'b0, 1'b1);
    check("unwind1", 32'(e_irw), 32'h3);
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b1);
    check("unwind3", 32'(e_irw), 32'h0);

    // Blocking by a higher in-service channel.
    step(3'b100); step(3'b000, 1'b1);
    step(3'b010);
    check("blk_req", 32'(e_req), 32'h0);
    check("blk_pend", 32'(e_pend), 32'h2);
    step(3'b000, 1'b0, 1'b1);
    check("blk_id", 32'(e_id), 32'h1);
    step(3'b000, 1'b1); step(3'b000, 1'b0, 1'b1);

    // Masking.
    step(3'b000, 1'b0, 1'b0, 1'b1, 3'b101);
    step(3'b010);
    check("mask_req", 32'(e_req), 32'h0);
    step(3'b000, 1'b0, 1'b0, 1'b1, 3'b111);
    check("unmask_id", 32'(e_id), 32'h1);
    step(3'b000, 1'b1); step(3'b000, 1'b0, 1'b1);

    // Overrun, clear, and a set event racing the ack of the same channel.
    step(3'b100); step(3'b000); step(3'b100); step(3'b000);
    check("ovf_set", 32'(e_ovf), 32'h4);
    step(3'b000, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("ovf_clr", 32'(e_ovf), 32'h0);
    step(3'b100, 1'b1);
    check("race_pend", 32'(e_pend[2]), 32'h1);
    check("race_ovf",  32'(e_ovf[2]),  32'h0);
    step(3'b000, 1'b0, 1'b1);

    // Level mode hold + ack, then reset mid-handler with the line still high.
    async_reset();
    step(3'b010);
    step(3'b010, 1'b1);
    check("lvl_irw",  32'(l_irw),  32'h2);
    check("lvl_pend", 32'(l_pend), 32'h2);
    async_reset();
    check("rst_irw", 32'(l_irw), 32'h0);
    step(3'b010);
    check("rst_edge", 32'(e_pend), 32'h2);

    // Random traffic, with an occasional asynchronous reset.
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] r_irq;
      r_irq = ($urandom_range(0, 2) == 0) ? N'($urandom) : irq & N'($urandom);
      step(r_irq, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), N'($urandom), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 149) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
